// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, FSM state type and helpers for the text load arbiter
package text_pkg;

  localparam int         NUM_REQ_DEFAULT = 3;
  localparam int         MAX_DISPLAY     = 99;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_SPACE     = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_ACK
  } arb_state_t;

  function automatic logic [6:0] saturate(input logic [6:0] v);
    return (v > 7'(MAX_DISPLAY)) ? 7'(MAX_DISPLAY) : v;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/text_dec_conv.sv
// rtl/text_dec_conv.sv - iterative subtract-10 binary to two-digit decimal converter
module text_dec_conv
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [6:0] rem;
  logic       active;

  // start latches the saturated value; one subtraction per cycle until rem < 10
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem    <= '0;
      tens   <= '0;
      active <= 1'b0;
    end else if (start) begin
      rem    <= saturate(value);
      tens   <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (rem >= 7'd10) begin
        rem  <= rem - 7'd10;
        tens <= tens + 4'd1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done  = active && (rem < 7'd10);
  assign units = rem[3:0];

endmodule

// File: rtl/text_load_arbiter.sv
// rtl/text_load_arbiter.sv - round-robin text RAM loader; TEXT_ARB_BLANK_ZERO_EN blanks a zero tens digit
module text_load_arbiter
  import text_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][6:0] value,
  output logic [NUM_REQ-1:0]      load_text,
  output logic [15:0]             text_in,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, win, grant_idx, cand_idx;
  logic             grant_found;
  int               cand;
  logic             conv_start, conv_done;
  logic [3:0]       conv_tens, conv_units;
  logic [7:0]       tens_char;

  // first requester at or above ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign conv_start = (state == ST_IDLE) && grant_found;

  text_dec_conv u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .value (value[grant_idx]),
    .done  (conv_done),
    .tens  (conv_tens),
    .units (conv_units)
  );

`ifdef TEXT_ARB_BLANK_ZERO_EN
  assign tens_char = (conv_tens == 4'd0) ? ASCII_SPACE : ascii_digit(conv_tens);
`else
  assign tens_char = ascii_digit(conv_tens);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // text_in is registered on the CONVERT->LOAD edge so it is valid during LOAD and holds afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      win     <= '0;
      text_in <= {ASCII_SPACE, ASCII_SPACE};
    end else begin
      if (conv_start) win <= grant_idx;
      if (state == ST_CONVERT && conv_done)
        text_in <= {tens_char, ascii_digit(conv_units)};
      if (state == ST_ACK)
        ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant_found) state_nxt = ST_CONVERT;
      ST_CONVERT: if (conv_done)   state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_text = '0;
    ack       = '0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_LOAD: load_text[win] = 1'b1;
      ST_ACK:  ack[win]       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_load_arbiter.sv
// tb/tb_text_load_arbiter.sv - self-checking bench for text_load_arbiter (vector table, corner sequences, random model)
module tb_text_load_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req;
  logic [2:0][6:0] value;
  logic [2:0]      load_text;
  logic [15:0]     text_in;
  logic [2:0]      ack;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  text_load_arbiter #(.NUM_REQ(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .value     (value),
    .load_text (load_text),
    .text_in   (text_in),
    .ack       (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [6:0]  v0, v1, v2;
    int          exp_w;
    logic [15:0] exp_txt;
    int          exp_load;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [15:0] exp_text(input int v);
    int s = sat(v);
    logic [7:0] tc = 8'(48 + s / 10);
`ifdef TEXT_ARB_BLANK_ZERO_EN
    if (s / 10 == 0) tc = 8'h20;
`endif
    return {tc, 8'(48 + s % 10)};
  endfunction

  function automatic int rr_pick(input int p, input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[(p + i) % 3]) return (p + i) % 3;
    return -1;
  endfunction

  function automatic logic [6:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 7'd0;
      1:       return 7'd99;
      2:       return 7'($urandom_range(100, 127));
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("rst_load", 32'(load_text), 32'd0);
    chk("rst_ack",  32'(ack),       32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_text", 32'(text_in),   32'h2020);
    rst_n     = 1'b1;
    model_ptr = 0;
  endtask

  // Called at a negedge of the grant cycle; returns at the negedge of the idle cycle after ack.
  task automatic serve(input int w, input logic [15:0] exp_txt, input int tens,
                       input bit keep, input bit rnd);
    int          load_k = -1, ack_k = -1, loads = 0;
    logic [2:0]  got_load = '0, got_ack = '0, nb;
    logic [15:0] got_txt = '0;
    bit          busy_ok = 1'b1, overlap = 1'b0;
    for (int k = 1; k <= 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (load_text != 0 && ack != 0) overlap = 1'b1;
      if (load_text != 0) begin
        loads++;
        load_k   = k;
        got_load = load_text;
        got_txt  = text_in;
      end
      if (ack != 0) begin
        ack_k   = k;
        got_ack = ack;
        if (!keep) req[w] = 1'b0;
      end
      if (k == 1 && rnd) begin
        value[w] = 7'($urandom_range(0, 127));
        nb = 3'($urandom_range(0, 7)) & ~req;
        for (int i = 0; i < 3; i++) if (nb[i]) value[i] = pick_val();
        req = req | nb;
      end
    end
    chk("load_latency", 32'(load_k),   32'(tens + 2));
    chk("load_onehot",  32'(got_load), 32'(3'b001 << w));
    chk("text_in",      32'(got_txt),  32'(exp_txt));
    chk("ack_latency",  32'(ack_k),    32'(tens + 3));
    chk("ack_onehot",   32'(got_ack),  32'(3'b001 << w));
    chk("single_load",  32'(loads),    32'd1);
    chk("busy_high",    32'(busy_ok),  32'd1);
    chk("no_overlap",   32'(overlap),  32'd0);
    model_ptr = (w + 1) % 3;
    @(negedge clk);
    chk("busy_idle", 32'(busy),    32'd0);
    chk("text_hold", 32'(text_in), 32'(exp_txt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    int          w, v;
    bit          seen;
    logic [2:0]  nb;
    logic [15:0] e5, e0;

    tbl[0] = '{3'b001, 7'd57,  7'd0,   7'd0,  0, 16'h3537, 7};
    tbl[1] = '{3'b010, 7'd0,   7'd120, 7'd0,  1, 16'h3939, 11};
    tbl[2] = '{3'b111, 7'd10,  7'd20,  7'd30, 2, 16'h3330, 5};
    tbl[3] = '{3'b011, 7'd99,  7'd45,  7'd0,  0, 16'h3939, 11};
    tbl[4] = '{3'b101, 7'd42,  7'd0,   7'd63, 2, 16'h3633, 8};
    tbl[5] = '{3'b110, 7'd0,   7'd10,  7'd77, 1, 16'h3130, 3};
    tbl[6] = '{3'b001, 7'd127, 7'd0,   7'd0,  0, 16'h3939, 11};
    tbl[7] = '{3'b100, 7'd0,   7'd0,   7'd19, 2, 16'h3139, 3};
`ifdef TEXT_ARB_BLANK_ZERO_EN
    e5 = 16'h2035; e0 = 16'h2030;
`else
    e5 = 16'h3035; e0 = 16'h3030;
`endif

    value = '0;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      req      = tbl[i].req;
      value[0] = tbl[i].v0;
      value[1] = tbl[i].v1;
      value[2] = tbl[i].v2;
      serve(tbl[i].exp_w, tbl[i].exp_txt, tbl[i].exp_load - 2, 1'b0, 1'b0);
    end

    // simultaneous requests after reset, then 101 with ptr back at 0
    do_reset();
    req = 3'b111; value[0] = 7'd11; value[1] = 7'd22; value[2] = 7'd33;
    serve(0, 16'h3131, 1, 1'b0, 1'b0);
    serve(1, 16'h3232, 2, 1'b0, 1'b0);
    serve(2, 16'h3333, 3, 1'b0, 1'b0);
    req = 3'b101; value[0] = 7'd44; value[2] = 7'd55;
    serve(0, 16'h3434, 4, 1'b0, 1'b0);
    serve(2, 16'h3535, 5, 1'b0, 1'b0);

    // leading-zero handling
    req = 3'b001; value[0] = 7'd5;
    serve(0, e5, 0, 1'b0, 1'b0);
    req = 3'b010; value[1] = 7'd0;
    serve(1, e0, 0, 1'b0, 1'b0);

    // reset during CONVERT aborts; ptr must restart at 0
    do_reset();
    req = 3'b001; value[0] = 7'd12;
    serve(0, 16'h3132, 1, 1'b0, 1'b0);
    req = 3'b010; value[1] = 7'd34;
    serve(1, 16'h3334, 3, 1'b0, 1'b0);
    req = 3'b001; value[0] = 7'd80;
    repeat (3) @(negedge clk);
    chk("abort_in_convert", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("abort_load", 32'(load_text), 32'd0);
    chk("abort_ack",  32'(ack),       32'd0);
    chk("abort_busy", 32'(busy),      32'd0);
    chk("abort_text", 32'(text_in),   32'h2020);
    rst_n = 1'b1;
    model_ptr = 0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (load_text != 0 || ack != 0 || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    req = 3'b110; value[1] = 7'd21; value[2] = 7'd65;
    serve(1, 16'h3231, 2, 1'b0, 1'b0);
    serve(2, 16'h3635, 6, 1'b0, 1'b0);

    // req held across ack is re-granted in the very next cycle
    req = 3'b010; value[1] = 7'd36;
    serve(1, 16'h3336, 3, 1'b1, 1'b0);
    serve(1, 16'h3336, 3, 1'b0, 1'b0);

    // randomized traffic against the round-robin / decimal model
    for (int n = 0; n < 60; n++) begin
      nb = 3'($urandom_range(0, 7)) & ~req;
      if ((req | nb) == 0) nb = 3'b001 << $urandom_range(0, 2);
      for (int i = 0; i < 3; i++) if (nb[i]) value[i] = pick_val();
      req = req | nb;
      w = rr_pick(model_ptr, req);
      v = int'(value[w]);
      serve(w, exp_text(v), sat(v) / 10, ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_load_arbiter.md
TEXT_LOAD_ARBITER -- requirements
Module: text_load_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of text requesters; each requester owns one two-character text RAM.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req  input  NUM_REQ  per-requester level request: new value to display.
REQ-005 value  input  NUM_REQ x 7  per-requester binary value, 0..127; only values 0..99 are displayable.
REQ-006 load_text  output  NUM_REQ  one-hot load strobe, one bit per text RAM.
REQ-007 text_in  output  16  two ASCII characters: [15:8] is the tens digit, [7:0] is the units digit.
REQ-008 ack  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, CONVERT, LOAD and ACK.
REQ-011 In IDLE with any req bit high, the arbiter SHALL grant exactly one requester by round-robin starting at pointer ptr, searching upward and wrapping.
REQ-012 The grant cycle SHALL latch the winner index w and the saturated value min(value[w], 99), then go to CONVERT; value changes after the grant cycle are ignored.
REQ-013 Each CONVERT cycle SHALL do one of the following:
- If the remainder is >= 10: subtract 10 and increment tens.
- Otherwise: go to LOAD.
- CONVERT therefore lasts tens+1 cycles.
REQ-014 In LOAD, load_text[w] SHALL be high for exactly one cycle, with text_in = {8'h30+tens, 8'h30+units} valid in the same cycle.
REQ-015 In ACK, ack[w] SHALL be high for exactly one cycle, ptr SHALL become (w+1) mod NUM_REQ, and the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be measured from grant cycle t: load at t+2+tens, ack at t+3+tens (value 0: t+2/t+3; value 99: t+11/t+12).
REQ-017 At most one load_text bit and at most one ack bit SHALL be high in any cycle; they are never high in the same cycle.
REQ-018 text_in SHALL hold its last loaded value between loads.
REQ-019 A requester SHALL drop req at the edge where it sees ack. A req still high in the following IDLE is a new request, arbitrated with ptr already advanced.
REQ-020 Requests arriving while busy SHALL be held pending, not lost, and are arbitrated at the next IDLE.

Reset
REQ-021 While rst_n is low at a clock edge, the block SHALL set:
- state = IDLE, ptr = 0;
- load_text = 0, ack = 0, busy = 0;
- text_in = 16'h2020.
REQ-022 Reset asserted mid-operation (CONVERT, LOAD or ACK) SHALL abort the transaction with no further load_text or ack for it.

Configuration
REQ-023 Macro TEXT_ARB_BLANK_ZERO_EN SHALL control the leading tens digit:
- Defined: a tens digit of 0 is emitted as 8'h20 (space), so value 7 gives 16'h2037.
- Undefined: the tens digit is always ASCII, so value 7 gives 16'h3037.

Structure
REQ-024 Shared package text_pkg SHALL hold:
- the NUM_REQ default;
- ASCII_ZERO = 8'h30 and ASCII_SPACE = 8'h20;
- the FSM state enum typedef;
- MAX_DISPLAY = 99.
REQ-025 Sub-module text_dec_conv SHALL contain the iterative subtract-10 converter (start and done handshake, tens/units outputs); the arbiter SHALL contain the FSM and round-robin logic.

Verification
REQ-026 Test: req[0] held with value 57 after reset, grant at t. Required: load_text=3'b001 at t+7 with text_in=16'h3537, ack[0] at t+8.
REQ-027 Test: req[1] with value 120. Required: saturation to text_in=16'h3939, load at t+11.
REQ-028 Test: req=3'b111 at the same time after reset, each requester dropping req on its own ack. Required: service order 0,1,2. Then req=3'b101 with ptr=0. Required: order 0,2.
REQ-029 Test: value 5, with TEXT_ARB_BLANK_ZERO_EN defined and then undefined. Required: text_in=16'h2035 defined, 16'h3035 undefined; value 0 gives 16'h2030 and 16'h3030 respectively.
REQ-030 Test: rst_n low during CONVERT of value 80. Required: no load_text or ack for it, and all outputs at reset values. Then req[2]. Required: served normally, ptr search starting at 0.
REQ-031 Test: req[1] held high across its ack with no other requests. Required: re-served, with a new grant in the cycle after ack.
